instruction_fetcher: RTL and testbench
======================================

Name: instruction_fetcher

Overview:
Fetch stage directly upstream of the direct-mapped instruction_cache and downstream of the memory controller. Holds the PC, probes the cache every cycle, and on a miss fetches the word from memory and writes it into the cache. Delivers (pc, instruction) pairs to the instruction queue through a one-entry output register with a valid/ready handshake. Accepts redirects (flush) from the commit stage on misprediction.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
PC_STEP, 4, sequential PC increment in bytes.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
rdy  input  1  global enable; when 0 all state and outputs hold, icache_wr forced 0.
flush  input  1  redirect request; highest priority.
flush_pc  input  32  new PC when flush=1.
icache_addr  output  32  lookup/write address; combinational, always equal to pc.
icache_hit  input  1  cache hit for icache_addr (combinational from cache).
icache_data  input  32  cached word for icache_addr.
icache_wr  output  1  cache write strobe (one cycle).
icache_wdata  output  32  word to write into cache.
mem_valid  output  1  memory word-read request.
mem_addr  output  32  request address (registered).
mem_ready  input  1  one-cycle pulse: mem_data valid, request complete.
mem_data  input  32  returned instruction word.
out_valid  output  1  out_inst/out_pc valid.
out_ready  input  1  instruction queue can accept.
out_inst  output  32  fetched instruction.
out_pc  output  32  address of out_inst.
out_pred_taken  output  1  predicted-taken flag (0 unless optional feature).

Behaviour:
- Reset (rst=1 at posedge, overrides rdy): pc=RESET_PC, state=FETCH, mem_valid=0, mem_addr=0, icache_wr=0, icache_wdata=0, out_valid=0, out_inst=0, out_pc=0, out_pred_taken=0. Reset mid-miss abandons the request; the memory controller is reset in the same cycle.
- rdy=0: no state changes; icache_wr=0.
- Output register "free" = !out_valid || out_ready. Transfer occurs when out_valid && out_ready; out_valid clears unless reloaded the same cycle.
- States: FETCH, MEM_WAIT, REFILL, DRAIN.
- FETCH: if icache_hit && free: out_valid<=1, out_inst<=icache_data, out_pc<=pc, pc<=pc+PC_STEP (mod 2^32). Hit && !free: hold. Miss: mem_valid<=1, mem_addr<=pc, go to MEM_WAIT. Throughput 1 instr/cycle on consecutive hits; hit-to-out_valid latency 1 cycle.
- MEM_WAIT: mem_valid held 1, mem_addr stable until mem_ready. On mem_ready: mem_valid<=0, icache_wdata<=mem_data, go to REFILL.
- REFILL: icache_wr=1 (combinational, this cycle only), icache_addr=pc; next state FETCH. Following FETCH cycle hits. Miss-to-out_valid = memory latency + 3 cycles.
- flush=1 (rdy=1): pc<=flush_pc, out_valid<=0, icache_wr suppressed. From FETCH/REFILL -> FETCH. From MEM_WAIT without mem_ready the same cycle -> DRAIN (request stays asserted). From MEM_WAIT with mem_ready the same cycle -> FETCH, data discarded.
- DRAIN: mem_valid held until mem_ready; response discarded, no cache write; -> FETCH. A further flush in DRAIN only updates pc.
- flush and out_ready same cycle: flush wins; the register's instruction counts as transferred only if out_valid was 1 before the edge (queue is flushed too).
- mem_valid never deasserts before mem_ready except on rst.

Optional Feature:
STATIC_JAL_PREDICT_EN. Defined: in FETCH on a delivered hit whose icache_data[6:0]==7'b1101111 (JAL), pc<=pc+sign-extended J-immediate {inst[31],inst[19:12],inst[20],inst[30:21],1'b0} and out_pred_taken<=1; all other instructions set out_pred_taken<=0. Undefined: pc always advances by PC_STEP, out_pred_taken constant 0.

Test Plan:
Reset, cache hits at 0x0,0x4,0x8 with out_ready=1 -> out_pc 0x0,0x4,0x8 on three consecutive cycles, no mem_valid.
Miss at 0x10, mem_ready 3 cycles after request with 0x00A00093 -> mem_addr=0x10, one-cycle icache_wr with icache_wdata=0x00A00093, out_inst=0x00A00093, out_pc=0x10 three cycles after mem_ready.
out_ready=0 for 4 cycles while hitting -> out_valid stays 1, out_pc frozen, pc not advanced; resumes at next address on release.
flush to 0x200 during MEM_WAIT for 0x40 -> mem_valid held until mem_ready, no icache_wr, next out_pc=0x200.
rdy=0 for 5 cycles mid-miss -> no output/state change, icache_wr=0; completes normally after rdy=1.
With STATIC_JAL_PREDICT_EN: hit at 0x100 returning 0x0100006F (jal +16) -> out_pred_taken=1, next out_pc=0x110; without macro next out_pc=0x104.

Source files
------------

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - fetch stage: PC, icache probe, miss refill, output register.
// Optional static JAL prediction enabled by defining STATIC_JAL_PREDICT_EN.
module instruction_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] icache_addr,
    input  logic        icache_hit,
    input  logic [31:0] icache_data,
    output logic        icache_wr,
    output logic [31:0] icache_wdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_pred_taken
);

    typedef enum logic [1:0] {FETCH, MEM_WAIT, REFILL, DRAIN} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;
    logic [31:0] icache_wdata_q;
    logic        out_valid_q;
    logic [31:0] out_inst_q;
    logic [31:0] out_pc_q;
    logic        out_pred_taken_q;

    logic        out_free;
    logic [31:0] pc_hit_d;
    logic        pred_d;

`ifdef STATIC_JAL_PREDICT_EN
    logic [31:0] jal_imm;
    assign jal_imm = {{11{icache_data[31]}}, icache_data[31], icache_data[19:12],
                      icache_data[20], icache_data[30:21], 1'b0};
`endif

    // Next PC after delivering the word currently returned by the cache.
    always_comb begin
        pc_hit_d = pc_q + 32'(PC_STEP);
        pred_d   = 1'b0;
`ifdef STATIC_JAL_PREDICT_EN
        if (icache_data[6:0] == 7'b1101111) begin
            pc_hit_d = pc_q + jal_imm;
            pred_d   = 1'b1;
        end
`endif
    end

    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= FETCH;
            pc_q             <= RESET_PC;
            mem_valid_q      <= 1'b0;
            mem_addr_q       <= 32'h0;
            icache_wdata_q   <= 32'h0;
            out_valid_q      <= 1'b0;
            out_inst_q       <= 32'h0;
            out_pc_q         <= 32'h0;
            out_pred_taken_q <= 1'b0;
        end else if (rdy) begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (flush) begin
                pc_q        <= flush_pc;
                out_valid_q <= 1'b0;
                // An outstanding memory request must still be retired before refetching.
                case (state_q)
                    MEM_WAIT, DRAIN: begin
                        if (mem_ready) begin
                            mem_valid_q <= 1'b0;
                            state_q     <= FETCH;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end else begin
                case (state_q)
                    FETCH: begin
                        if (icache_hit) begin
                            if (out_free) begin
                                out_valid_q      <= 1'b1;
                                out_inst_q       <= icache_data;
                                out_pc_q         <= pc_q;
                                out_pred_taken_q <= pred_d;
                                pc_q             <= pc_hit_d;
                            end
                        end else begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= pc_q;
                            state_q     <= MEM_WAIT;
                        end
                    end
                    MEM_WAIT: begin
                        if (mem_ready) begin
                            mem_valid_q    <= 1'b0;
                            icache_wdata_q <= mem_data;
                            state_q        <= REFILL;
                        end
                    end
                    REFILL: state_q <= FETCH;
                    DRAIN: begin
                        if (mem_ready) begin
                            mem_valid_q <= 1'b0;
                            state_q     <= FETCH;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    assign icache_addr    = pc_q;
    assign icache_wr      = (state_q == REFILL) && rdy && !flush && !rst;
    assign icache_wdata   = icache_wdata_q;
    assign mem_valid      = mem_valid_q;
    assign mem_addr       = mem_addr_q;
    assign out_valid      = out_valid_q;
    assign out_inst       = out_inst_q;
    assign out_pc         = out_pc_q;
    assign out_pred_taken = out_pred_taken_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - directed scoreboard bench for instruction_fetcher.
module tb_instruction_fetcher;

`ifdef STATIC_JAL_PREDICT_EN
    localparam bit JAL_ON = 1'b1;
`else
    localparam bit JAL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic [31:0] flush_pc;
    logic [31:0] icache_addr;
    logic        icache_hit;
    logic [31:0] icache_data;
    logic        icache_wr;
    logic [31:0] icache_wdata;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic        out_valid, out_ready;
    logic [31:0] out_inst, out_pc;
    logic        out_pred_taken;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    bit [31:0] cdata[256];
    bit [21:0] ctag[256];
    bit        cvalid[256];
    logic        pre_en;
    logic [31:0] pre_addr, pre_data;
    int          mcnt;
    localparam int MEM_LAT = 3;

    always #5 clk = ~clk;

    instruction_fetcher #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .flush_pc(flush_pc),
        .icache_addr(icache_addr), .icache_hit(icache_hit), .icache_data(icache_data),
        .icache_wr(icache_wr), .icache_wdata(icache_wdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_pred_taken(out_pred_taken)
    );

    function automatic logic [31:0] cword(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        return (a == 32'h10) ? 32'h00A0_0093 : (32'h5A00_0000 | a);
    endfunction

    // Direct-mapped cache model: 256 words, index addr[9:2].
    assign icache_hit  = cvalid[icache_addr[9:2]] && (ctag[icache_addr[9:2]] == icache_addr[31:10]);
    assign icache_data = cdata[icache_addr[9:2]];

    always @(posedge clk) begin
        if (icache_wr) begin
            cvalid[icache_addr[9:2]] <= 1'b1;
            ctag[icache_addr[9:2]]   <= icache_addr[31:10];
            cdata[icache_addr[9:2]]  <= icache_wdata;
        end else if (pre_en) begin
            cvalid[pre_addr[9:2]] <= 1'b1;
            ctag[pre_addr[9:2]]   <= pre_addr[31:10];
            cdata[pre_addr[9:2]]  <= pre_data;
        end
    end

    // Memory controller model: completes a request MEM_LAT enabled cycles after it appears.
    always @(posedge clk) begin
        if (rst) begin
            mcnt      <= 0;
            mem_ready <= 1'b0;
            mem_data  <= 32'h0;
        end else if (rdy) begin
            mem_ready <= 1'b0;
            if (mem_valid && !mem_ready) begin
                if (mcnt == MEM_LAT - 1) begin
                    mem_ready <= 1'b1;
                    mem_data  <= mword(mem_addr);
                    mcnt      <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
        exp_t x;
        x.pc = pc; x.inst = inst; x.pred = pred;
        sb.push_back(x);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    // Scoreboard: every transfer on the output handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && rdy && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_extra observed pc %h expected no transfer", out_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_inst", out_inst, e.inst);
                chk("sb_pred", {31'b0, out_pred_taken}, {31'b0, e.pred});
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; flush_pc = 32'h0; out_ready = 1'b1;
        pre_en = 1'b0; pre_addr = 32'h0; pre_data = 32'h0;
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk("rst_icache_wr", {31'b0, icache_wr}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_icache_wdata", icache_wdata, 32'h0);
        chk("rst_pred", {31'b0, out_pred_taken}, 32'h0);
        chk("rst_pc", icache_addr, 32'h0);

        for (int a = 0; a <= 32'h3C; a += 4)
            if (a != 32'h10) preload(32'(a), cword(32'(a)));
        preload(32'h200, cword(32'h200));
        preload(32'h204, cword(32'h204));
        preload(32'h100, 32'h0100_006F);
        preload(32'h104, cword(32'h104));
        preload(32'h110, cword(32'h110));

        // Consecutive hits then a miss at 0x10.
        for (int a = 0; a <= 32'h3C; a += 4)
            push(32'(a), (a == 32'h10) ? 32'h00A0_0093 : cword(32'(a)), 1'b0);
        rst = 1'b0;
        tick();
        chk("hit0_valid", {31'b0, out_valid}, 32'h1);
        chk("hit0_pc", out_pc, 32'h0);
        chk("hit0_mem_valid", {31'b0, mem_valid}, 32'h0);
        tick();
        chk("hit1_pc", out_pc, 32'h4);
        chk("hit1_mem_valid", {31'b0, mem_valid}, 32'h0);
        tick();
        chk("hit2_pc", out_pc, 32'h8);
        chk("hit2_mem_valid", {31'b0, mem_valid}, 32'h0);
        tick();
        chk("hit3_pc", out_pc, 32'hC);
        tick();
        chk("miss_mem_valid", {31'b0, mem_valid}, 32'h1);
        chk("miss_mem_addr", mem_addr, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("miss_wait_wr", {31'b0, icache_wr}, 32'h0);
            chk("miss_wait_mv", {31'b0, mem_valid}, 32'h1);
        end
        tick();
        chk("refill_wr", {31'b0, icache_wr}, 32'h1);
        chk("refill_wdata", icache_wdata, 32'h00A0_0093);
        chk("refill_addr", icache_addr, 32'h10);
        chk("refill_mem_valid", {31'b0, mem_valid}, 32'h0);
        tick();
        chk("refill_wr_once", {31'b0, icache_wr}, 32'h0);
        chk("refill_out_idle", {31'b0, out_valid}, 32'h0);
        tick();
        chk("miss_out_valid", {31'b0, out_valid}, 32'h1);
        chk("miss_out_pc", out_pc, 32'h10);
        chk("miss_out_inst", out_inst, 32'h00A0_0093);

        // Back-pressure while hitting.
        tick();
        chk("pre_stall_pc", out_pc, 32'h14);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_out_pc", out_pc, 32'h14);
            chk("stall_pc", icache_addr, 32'h18);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_pc", out_pc, 32'h18);

        // Flush to 0x200 while waiting on the 0x40 miss.
        for (int i = 0; i < 40 && !mem_valid; i++) tick();
        chk("f_req", {31'b0, mem_valid}, 32'h1);
        chk("f_addr", mem_addr, 32'h40);
        push(32'h200, cword(32'h200), 1'b0);
        push(32'h204, cword(32'h204), 1'b0);
        flush = 1'b1; flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        chk("f_hold", {31'b0, mem_valid}, 32'h1);
        chk("f_pc", icache_addr, 32'h200);
        chk("f_out_valid", {31'b0, out_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f_no_wr", {31'b0, icache_wr}, 32'h0);
        end
        chk("f_done", {31'b0, mem_valid}, 32'h0);
        tick();
        chk("f_out_valid2", {31'b0, out_valid}, 32'h1);
        chk("f_out_pc", out_pc, 32'h200);

        // rdy low in the middle of the 0x208 miss, and again during refill.
        push(32'h208, mword(32'h208), 1'b0);
        for (int i = 0; i < 40 && !mem_valid; i++) tick();
        chk("r_req", {31'b0, mem_valid}, 32'h1);
        chk("r_addr", mem_addr, 32'h208);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("r_mv", {31'b0, mem_valid}, 32'h1);
            chk("r_mem_addr", mem_addr, 32'h208);
            chk("r_ov", {31'b0, out_valid}, 32'h0);
            chk("r_wr", {31'b0, icache_wr}, 32'h0);
            chk("r_pc", icache_addr, 32'h208);
        end
        rdy = 1'b1;
        for (int i = 0; i < 20 && !icache_wr; i++) tick();
        chk("r_wr_seen", {31'b0, icache_wr}, 32'h1);
        chk("r_wdata", icache_wdata, mword(32'h208));
        rdy = 1'b0;
        #1;
        chk("r_wr_gated", {31'b0, icache_wr}, 32'h0);
        tick();
        chk("r_wr_gated2", {31'b0, icache_wr}, 32'h0);
        rdy = 1'b1;
        #1;
        chk("r_wr_again", {31'b0, icache_wr}, 32'h1);
        for (int i = 0; i < 20 && !(out_valid && out_pc == 32'h208); i++) tick();
        chk("r_out_seen", {31'b0, out_valid && out_pc == 32'h208}, 32'h1);

        // JAL at 0x100 reached by a flush during the 0x20C miss.
        for (int i = 0; i < 40 && !mem_valid; i++) tick();
        chk("j_addr", mem_addr, 32'h20C);
        push(32'h100, 32'h0100_006F, JAL_ON);
        push(JAL_ON ? 32'h110 : 32'h104, cword(JAL_ON ? 32'h110 : 32'h104), 1'b0);
        flush = 1'b1; flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 20 && !(out_valid && out_pc == 32'h100); i++) tick();
        chk("j_seen", {31'b0, out_valid && out_pc == 32'h100}, 32'h1);
        chk("j_pred", {31'b0, out_pred_taken}, {31'b0, JAL_ON});
        tick();
        chk("j_next_pc", out_pc, JAL_ON ? 32'h110 : 32'h104);
        chk("j_next_pred", {31'b0, out_pred_taken}, 32'h0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        rdy = 1'b0;
        chk("sb_empty", 32'(sb.size()), 32'h0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
